exec_stage_param: RTL

//  Parametrised execute stage: registered ALU between decode and memory/writeback.

---
 rtl/exec_stage_param.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_stage_param.sv
// Parametrised execute stage: registered ALU with valid/ready handshake, back-pressure,
// iterative shift-add multiplier, status flags and illegal-opcode detection.
module exec_stage_param #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned MEM_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            opcode,
    input  logic [DATA_W-1:0]     operand1,
    input  logic [DATA_W-1:0]     operand2,
    input  logic                  write_enable,
    input  logic                  store_enable,
    input  logic                  load_enable,
    input  logic [REG_ADDR_W-1:0] reg_addr,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     result,
    output logic                  zero,
    output logic                  carry,
    output logic                  ovf,
    output logic                  illegal_op,
    output logic                  write_enable_out,
    output logic                  store_enable_out,
    output logic                  load_enable_out,
    output logic [REG_ADDR_W-1:0] reg_addr_out,
    output logic [MEM_ADDR_W-1:0] mem_addr_out
);

    localparam int unsigned SHAMT_W = $clog2(DATA_W);
    localparam logic [SHAMT_W-1:0] CntLast = SHAMT_W'(DATA_W - 1);

    typedef enum logic [3:0] {
        OpNop   = 4'h0,
        OpAdd   = 4'h1,
        OpSub   = 4'h2,
        OpLoad  = 4'h3,
        OpStore = 4'h4,
        OpAnd   = 4'h5,
        OpOr    = 4'h6,
        OpXor   = 4'h7,
        OpShl   = 4'h8,
        OpShr   = 4'h9,
        OpMul   = 4'hA
    } op_e;

    typedef enum logic {
        StIdle,
        StMul
    } state_e;

    state_e                  state_q, state_d;
    logic [SHAMT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W-1:0]     mcand_q, mcand_d;
    logic [DATA_W-1:0]       mplier_q, mplier_d;
    logic [2*DATA_W-1:0]     acc_q, acc_d;
    logic [2*DATA_W-1:0]     acc_next;

    // Sidebands of an in-flight MUL, released to the outputs with its result
    logic                    p_we_q, p_we_d, p_st_q, p_st_d, p_ld_q, p_ld_d;
    logic [REG_ADDR_W-1:0]   p_reg_addr_q, p_reg_addr_d;
    logic [MEM_ADDR_W-1:0]   p_mem_addr_q, p_mem_addr_d;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_W-1:0]       result_q, result_d;
    logic                    zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
    logic                    illegal_q, illegal_d;
    logic                    we_q, we_d, st_q, st_d, ld_q, ld_d;
    logic [REG_ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic                    accept, consume;
    logic [DATA_W:0]         sum_ext, diff_ext;
    logic [DATA_W-1:0]       alu_result;
    logic                    alu_carry, alu_ovf, alu_illegal, alu_en_pass;

    assign in_ready = !rst && (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    assign sum_ext  = {1'b0, operand1} + {1'b0, operand2};
    assign diff_ext = {1'b0, operand1} - {1'b0, operand2};
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_result  = '0;
        alu_carry   = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        alu_en_pass = 1'b1;
        case (opcode)
            OpNop: alu_en_pass = 1'b0;
            OpAdd: begin
                alu_result = sum_ext[DATA_W-1:0];
                alu_carry  = sum_ext[DATA_W];
                alu_ovf    = (operand1[DATA_W-1] == operand2[DATA_W-1]) &&
                             (sum_ext[DATA_W-1] != operand1[DATA_W-1]);
            end
            OpSub: begin
                alu_result = diff_ext[DATA_W-1:0];
                alu_carry  = diff_ext[DATA_W];
                alu_ovf    = (operand1[DATA_W-1] != operand2[DATA_W-1]) &&
                             (diff_ext[DATA_W-1] != operand1[DATA_W-1]);
            end
            OpLoad:  alu_result = operand1;
            OpStore: alu_result = operand1;
            OpAnd:   alu_result = operand1 & operand2;
            OpOr:    alu_result = operand1 | operand2;
            OpXor:   alu_result = operand1 ^ operand2;
            OpShl:   alu_result = operand1 << operand2[SHAMT_W-1:0];
            OpShr:   alu_result = operand1 >> operand2[SHAMT_W-1:0];
            OpMul:   alu_result = '0;
            default: begin
                alu_illegal = 1'b1;
                alu_en_pass = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        p_we_d       = p_we_q;
        p_st_d       = p_st_q;
        p_ld_d       = p_ld_q;
        p_reg_addr_d = p_reg_addr_q;
        p_mem_addr_d = p_mem_addr_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        zero_d       = zero_q;
        carry_d      = carry_q;
        ovf_d        = ovf_q;
        illegal_d    = illegal_q;
        we_d         = we_q;
        st_d         = st_q;
        ld_d         = ld_q;
        reg_addr_d   = reg_addr_q;
        mem_addr_d   = mem_addr_q;

        unique case (state_q)
            StIdle: begin
                if (accept && opcode == OpMul) begin
                    state_d      = StMul;
                    cnt_d        = '0;
                    mcand_d      = {{DATA_W{1'b0}}, operand1};
                    mplier_d     = operand2;
                    acc_d        = '0;
                    p_we_d       = write_enable;
                    p_st_d       = store_enable;
                    p_ld_d       = load_enable;
                    p_reg_addr_d = reg_addr;
                    p_mem_addr_d = mem_addr;
                    out_valid_d  = 1'b0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_result;
                    zero_d      = (alu_result == '0);
                    carry_d     = alu_carry;
                    ovf_d       = alu_ovf;
                    illegal_d   = alu_illegal;
                    we_d        = write_enable && alu_en_pass;
                    st_d        = store_enable && alu_en_pass;
                    ld_d        = load_enable && alu_en_pass;
                    reg_addr_d  = reg_addr;
                    mem_addr_d  = mem_addr;
                end else if (consume) begin
                    out_valid_d = 1'b0;
                end
            end
            StMul: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    result_d    = acc_next[DATA_W-1:0];
                    zero_d      = (acc_next[DATA_W-1:0] == '0);
                    carry_d     = |acc_next[2*DATA_W-1:DATA_W];
                    ovf_d       = 1'b0;
                    illegal_d   = 1'b0;
                    we_d        = p_we_q;
                    st_d        = p_st_q;
                    ld_d        = p_ld_q;
                    reg_addr_d  = p_reg_addr_q;
                    mem_addr_d  = p_mem_addr_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            p_we_q       <= 1'b0;
            p_st_q       <= 1'b0;
            p_ld_q       <= 1'b0;
            p_reg_addr_q <= '0;
            p_mem_addr_q <= '0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
            illegal_q    <= 1'b0;
            we_q         <= 1'b0;
            st_q         <= 1'b0;
            ld_q         <= 1'b0;
            reg_addr_q   <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            p_we_q       <= p_we_d;
            p_st_q       <= p_st_d;
            p_ld_q       <= p_ld_d;
            p_reg_addr_q <= p_reg_addr_d;
            p_mem_addr_q <= p_mem_addr_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            carry_q      <= carry_d;
            ovf_q        <= ovf_d;
            illegal_q    <= illegal_d;
            we_q         <= we_d;
            st_q         <= st_d;
            ld_q         <= ld_d;
            reg_addr_q   <= reg_addr_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign result           = result_q;
    assign zero             = zero_q;
    assign carry            = carry_q;
    assign ovf              = ovf_q;
    assign illegal_op       = illegal_q;
    assign write_enable_out = we_q;
    assign store_enable_out = st_q;
    assign load_enable_out  = ld_q;
    assign reg_addr_out     = reg_addr_q;
    assign mem_addr_out     = mem_addr_q;

endmodule
